// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch sequencer for a dual-issue front end.
//
// Each access reads one pair of 32-bit instructions from instruction memory.
// The memory has a 1-cycle registered read. This block:
//   - generates the fetch PC,
//   - tracks the access in flight,
//   - buffers returned pairs in an output register plus a 1-deep skid, so
//     decode back-pressure never drops a pair,
//   - handles redirects, end-of-program (a zero instruction word) and the
//     end of memory.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin fetching at PC 0 (sampled in IDLE only)
//   pc                  fetch address driven to the fetch unit
//   inst1_in/inst2_in   fetched pair; valid the cycle after its pc is issued
//   stall               decode cannot accept the current output pair
//   redirect_valid/_pc  flush and restart at redirect_pc (low 2 bits ignored)
//   out_valid1/2        slot valid flags
//   out_inst1/2         slot instructions
//   out_pc              byte address of out_inst1
//   done                high in HALT
//   perf_pairs          pairs popped by decode (saturating)
//   perf_stalls         stalled cycles with valid output (saturating)
//
// Optional feature: define FETCH_PERF_CNT_EN to build the performance
// counters. When it is undefined, both perf ports are tied to zero.
module fetch_ctrl #(
  parameter int unsigned PC_W      = 8,
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned INST_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] inst1_in,
  input  logic [INST_W-1:0] inst2_in,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              out_valid1,
  output logic              out_valid2,
  output logic [INST_W-1:0] out_inst1,
  output logic [INST_W-1:0] out_inst2,
  output logic [PC_W-1:0]   out_pc,
  output logic              done,
  output logic [15:0]       perf_pairs,
  output logic [15:0]       perf_stalls
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALT} state_t;

  // Address compares use one extra bit so that base+4 cannot wrap.
  localparam logic [PC_W:0] MEM_END   = (PC_W+1)'(MEM_BYTES);
  localparam logic [PC_W:0] LAST_BASE = (PC_W+1)'(MEM_BYTES - 8);
  localparam logic [PC_W:0] SLOT2_OFS = (PC_W+1)'(4);
  localparam logic [PC_W-1:0] PAIR_INC = PC_W'(8);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                inflight_q, inflight_d;
  logic [PC_W-1:0]     tag_q, tag_d;

  logic                ov1_q, ov1_d, ov2_q, ov2_d;
  logic [INST_W-1:0]   oi1_q, oi1_d, oi2_q, oi2_d;
  logic [PC_W-1:0]     opc_q, opc_d;

  logic                sk_full_q, sk_full_d, sk_v2_q, sk_v2_d;
  logic [INST_W-1:0]   sk_i1_q, sk_i1_d, sk_i2_q, sk_i2_d;
  logic [PC_W-1:0]     sk_pc_q, sk_pc_d;

  logic                pop;
  logic [1:0]          occ;
  logic                can_issue;
  logic                slot1_in_mem, slot2_in_mem;
  logic                in_ok1, in_ok2, zero_hit;

  // Classify the pair returning for the access issued last cycle.
  always_comb begin
    slot1_in_mem = {1'b0, tag_q} < MEM_END;
    slot2_in_mem = ({1'b0, tag_q} + SLOT2_OFS) < MEM_END;
    in_ok1   = inflight_q && slot1_in_mem && (inst1_in != '0);
    in_ok2   = in_ok1 && slot2_in_mem && (inst2_in != '0);
    zero_hit = inflight_q && ((slot1_in_mem && (inst1_in == '0)) ||
                              (slot1_in_mem && slot2_in_mem && (inst2_in == '0)));
    pop       = ov1_q && !stall;
    occ       = 2'(ov1_q) + 2'(sk_full_q) + 2'(inflight_q);
    can_issue = (occ - 2'(pop)) < 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    tag_d      = tag_q;
    ov1_d      = ov1_q;
    ov2_d      = ov2_q;
    oi1_d      = oi1_q;
    oi2_d      = oi2_q;
    opc_d      = opc_q;
    sk_full_d  = sk_full_q;
    sk_v2_d    = sk_v2_q;
    sk_i1_d    = sk_i1_q;
    sk_i2_d    = sk_i2_q;
    sk_pc_d    = sk_pc_q;

    // Output/skid movement: the skid refills the output before any newly
    // returned pair, which keeps delivery in fetch order.
    if (pop) begin
      if (sk_full_q) begin
        ov1_d     = 1'b1;
        ov2_d     = sk_v2_q;
        oi1_d     = sk_i1_q;
        oi2_d     = sk_i2_q;
        opc_d     = sk_pc_q;
        sk_full_d = 1'b0;
      end else begin
        ov1_d = 1'b0;
        ov2_d = 1'b0;
      end
    end
    if (in_ok1) begin
      if (!ov1_q || (pop && !sk_full_q)) begin
        ov1_d = 1'b1;
        ov2_d = in_ok2;
        oi1_d = inst1_in;
        oi2_d = inst2_in;
        opc_d = tag_q;
      end else begin
        sk_full_d = 1'b1;
        sk_v2_d   = in_ok2;
        sk_i1_d   = inst1_in;
        sk_i2_d   = inst2_in;
        sk_pc_d   = tag_q;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
        end
      end
      S_RUN: begin
        if (zero_hit) begin
          state_d = S_DRAIN;
        end else if (can_issue) begin
          inflight_d = 1'b1;
          tag_d      = pc_q;
          pc_d       = pc_q + PAIR_INC;
          if ({1'b0, pc_q} >= LAST_BASE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight_q && !sk_full_q && !ov1_q) state_d = S_HALT;
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides everything above, including a pending capture.
    if (redirect_valid && (state_q != S_IDLE)) begin
      state_d    = S_RUN;
      pc_d       = {redirect_pc[PC_W-1:2], 2'b00};
      inflight_d = 1'b0;
      ov1_d      = 1'b0;
      ov2_d      = 1'b0;
      sk_full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      tag_q      <= '0;
      ov1_q      <= 1'b0;
      ov2_q      <= 1'b0;
      oi1_q      <= '0;
      oi2_q      <= '0;
      opc_q      <= '0;
      sk_full_q  <= 1'b0;
      sk_v2_q    <= 1'b0;
      sk_i1_q    <= '0;
      sk_i2_q    <= '0;
      sk_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      ov1_q      <= ov1_d;
      ov2_q      <= ov2_d;
      oi1_q      <= oi1_d;
      oi2_q      <= oi2_d;
      opc_q      <= opc_d;
      sk_full_q  <= sk_full_d;
      sk_v2_q    <= sk_v2_d;
      sk_i1_q    <= sk_i1_d;
      sk_i2_q    <= sk_i2_d;
      sk_pc_q    <= sk_pc_d;
    end
  end

  assign pc         = pc_q;
  assign out_valid1 = ov1_q;
  assign out_valid2 = ov2_q;
  assign out_inst1  = oi1_q;
  assign out_inst2  = oi2_q;
  assign out_pc     = opc_q;
  assign done       = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] pairs_q, pairs_d, stalls_q, stalls_d;

  always_comb begin
    pairs_d  = pairs_q;
    stalls_d = stalls_q;
    if (pop && (pairs_q != '1)) pairs_d = pairs_q + 16'd1;
    if (stall && ov1_q && (stalls_q != '1)) stalls_d = stalls_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pairs_q  <= '0;
      stalls_q <= '0;
    end else begin
      pairs_q  <= pairs_d;
      stalls_q <= stalls_d;
    end
  end

  assign perf_pairs  = pairs_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_pairs  = '0;
  assign perf_stalls = '0;
`endif

endmodule
